// File: rtl/arm_mc_pkg.sv
// Shared types and encodings for the multicycle ARM controller.
// Holds the state enum, control field codes and the DP command decode.
package arm_mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWRITE,
    S_MEMWB,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BRANCH,
    S_FAULT
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_ORR = 3'b011;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_DP  = 2'b00;
  localparam logic [1:0] IMM_MEM = 2'b01;
  localparam logic [1:0] IMM_BR  = 2'b10;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_MOV = 4'b1101;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;

  typedef struct packed {
    logic       legal;
    logic [2:0] alu;
    logic       nzcv;
    logic       cmp;
    logic       mov;
  } dp_dec_t;

  function automatic dp_dec_t dp_decode(input logic [3:0] cmd);
    dp_dec_t d;
    d = '{legal: 1'b1, alu: ALU_ADD,
          nzcv: 1'b0, cmp: 1'b0, mov: 1'b0};
    unique case (1'b1)
      (cmd == CMD_ADD): d.nzcv = 1'b1;
      (cmd == CMD_SUB): begin
        d.alu  = ALU_SUB;
        d.nzcv = 1'b1;
      end
      (cmd == CMD_AND): d.alu = ALU_AND;
      (cmd == CMD_ORR): d.alu = ALU_ORR;
      (cmd == CMD_CMP): begin
        d.alu  = ALU_SUB;
        d.nzcv = 1'b1;
        d.cmp  = 1'b1;
      end
      (cmd == CMD_MOV): d.mov = 1'b1;
      default: d.legal = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/arm_mc_controller_if.sv
// Controller <-> datapath bundle: instruction, flags, memory handshake
// and all control strobes. master = controller, slave = datapath.
interface arm_mc_controller_if #(
  parameter int ALUCTRL_W = 3
) ();
  logic [31:0]          Instr;
  logic [3:0]           ALUFlags;
  logic                 mem_ready;
  logic                 mem_req;
  logic                 PCWrite;
  logic                 AdrSrc;
  logic                 MemWrite;
  logic                 IRWrite;
  logic                 RegWrite;
  logic [1:0]           ResultSrc;
  logic                 ALUSrcA;
  logic [1:0]           ALUSrcB;
  logic [1:0]           ImmSrc;
  logic [1:0]           RegSrc;
  logic [ALUCTRL_W-1:0] ALUControl;
  logic                 mov;
  logic                 fault;

  modport master (
    input  Instr, ALUFlags, mem_ready,
    output mem_req, PCWrite, AdrSrc, MemWrite,
    output IRWrite, RegWrite, ResultSrc,
    output ALUSrcA, ALUSrcB, ImmSrc, RegSrc,
    output ALUControl, mov, fault
  );

  modport slave (
    output Instr, ALUFlags, mem_ready,
    input  mem_req, PCWrite, AdrSrc, MemWrite,
    input  IRWrite, RegWrite, ResultSrc,
    input  ALUSrcA, ALUSrcB, ImmSrc, RegSrc,
    input  ALUControl, mov, fault
  );
endinterface

// File: rtl/arm_cond_unit.sv
// NZCV flag register and condition-code evaluation.
// Flags load only when the owning instruction itself passes its condition.
module arm_cond_unit
  import arm_mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cond,
  input  logic [3:0] alu_flags,
  input  logic       flag_we,
  input  logic       nzcv_we,
  output logic       cond_ex
);

  logic [3:0] flags_q, flags_d;
  logic n, z, c, v;

  assign {n, z, c, v} = flags_q;

  // evaluate the condition field against the stored flags
  always_comb begin
    cond_ex = 1'b0;
    unique case (cond)
      COND_EQ: cond_ex = z;
      COND_NE: cond_ex = ~z;
      COND_CS: cond_ex = c;
      COND_CC: cond_ex = ~c;
      COND_MI: cond_ex = n;
      COND_PL: cond_ex = ~n;
      COND_VS: cond_ex = v;
      COND_VC: cond_ex = ~v;
      COND_HI: cond_ex = c & ~z;
      COND_LS: cond_ex = ~c | z;
      COND_GE: cond_ex = (n == v);
      COND_LT: cond_ex = (n != v);
      COND_GT: cond_ex = ~z & (n == v);
      COND_LE: cond_ex = z | (n != v);
      COND_AL: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  // logic ops only touch N and Z; arithmetic ops load all four
  always_comb begin
    flags_d = flags_q;
    if (flag_we && cond_ex) begin
      flags_d[3:2] = alu_flags[3:2];
      if (nzcv_we) flags_d[1:0] = alu_flags[1:0];
    end
  end

  // flag register
  always_ff @(posedge clk) begin
    if (reset) flags_q <= 4'b0000;
    else       flags_q <= flags_d;
  end

endmodule

// File: rtl/arm_mc_controller.sv
// Multicycle ARM control FSM with memory-ready stalls and fault state.
// Define ARM_PERF_EN to add the retired / stall_cycles counters.
module arm_mc_controller
  import arm_mc_pkg::*;
#(
  parameter int ALUCTRL_W = 3,
  parameter int TIMEOUT   = 0,
  parameter int CNT_W     = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  arm_mc_controller_if.master  bus
`ifdef ARM_PERF_EN
  ,
  output logic [CNT_W-1:0]     retired,
  output logic [CNT_W-1:0]     stall_cycles
`endif
);

  state_t  state_q, state_d, state_nxt;
  dp_dec_t dp;

  logic [1:0] op;
  logic [3:0] cmd;
  logic       s_bit, l_bit, u_bit, i_bit, rd15;
  logic       cond_ex, in_exec, in_mem;
  logic       mem_wait, timeout_hit;

  logic       mreq, pcw, adr, memw, irw, regw;
  logic       srca, mov_o;
  logic [1:0] res, srcb;
  logic [2:0] alu;

  logic unused_instr;

  assign op    = bus.Instr[27:26];
  assign i_bit = bus.Instr[25];
  assign cmd   = bus.Instr[24:21];
  assign u_bit = bus.Instr[23];
  assign s_bit = bus.Instr[20];
  assign l_bit = bus.Instr[20];
  assign rd15  = &bus.Instr[15:12];
  assign dp    = dp_decode(cmd);

  assign unused_instr =
    ^{bus.Instr[19:16], bus.Instr[11:0]};

  assign in_exec = (state_q == S_EXECR) |
                   (state_q == S_EXECI);
  assign in_mem  = (state_q == S_FETCH)   |
                   (state_q == S_MEMREAD) |
                   (state_q == S_MEMWRITE);
  assign mem_wait = in_mem & ~bus.mem_ready;

  arm_cond_unit u_cond (
    .clk       (clk),
    .reset     (reset),
    .cond      (bus.Instr[31:28]),
    .alu_flags (bus.ALUFlags),
    .flag_we   (in_exec & s_bit & dp.legal),
    .nzcv_we   (dp.nzcv),
    .cond_ex   (cond_ex)
  );

  // next-state: instruction sequencing, overridden by a memory timeout
  always_comb begin
    state_nxt = state_q;
    unique case (state_q)
      S_FETCH:
        if (bus.mem_ready) state_nxt = S_DECODE;
      S_DECODE:
        unique case (op)
          OP_DP:   state_nxt = i_bit ? S_EXECI : S_EXECR;
          OP_MEM:  state_nxt = S_MEMADR;
          OP_BR:   state_nxt = S_BRANCH;
          default: state_nxt = S_FAULT;
        endcase
      S_MEMADR:
        state_nxt = l_bit ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:
        if (bus.mem_ready) state_nxt = S_MEMWB;
      S_MEMWRITE:
        if (bus.mem_ready) state_nxt = S_FETCH;
      S_EXECR, S_EXECI:
        state_nxt = dp.legal ? S_ALUWB : S_FAULT;
      S_MEMWB, S_ALUWB, S_BRANCH:
        state_nxt = S_FETCH;
      S_FAULT:
        state_nxt = S_FAULT;
      default:
        state_nxt = S_FAULT;
    endcase
    state_d = timeout_hit ? S_FAULT : state_nxt;
  end

  // state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Moore control word per state
  always_comb begin
    mreq  = 1'b0;
    pcw   = 1'b0;
    adr   = 1'b0;
    memw  = 1'b0;
    irw   = 1'b0;
    regw  = 1'b0;
    res   = RES_ALUOUT;
    srca  = 1'b0;
    srcb  = SRCB_RD2;
    alu   = ALU_ADD;
    mov_o = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        mreq = 1'b1;
        srca = 1'b1;
        srcb = SRCB_FOUR;
        res  = RES_ALURES;
        irw  = bus.mem_ready;
        pcw  = bus.mem_ready;
      end
      S_DECODE: begin
        srca = 1'b1;
        srcb = SRCB_FOUR;
        res  = RES_ALURES;
      end
      S_MEMADR: begin
        srcb = SRCB_IMM;
        alu  = u_bit ? ALU_ADD : ALU_SUB;
      end
      S_MEMREAD: begin
        mreq = 1'b1;
        adr  = 1'b1;
      end
      S_MEMWRITE: begin
        mreq = 1'b1;
        adr  = 1'b1;
        memw = cond_ex;
      end
      S_MEMWB: begin
        res  = RES_DATA;
        regw = cond_ex;
        pcw  = cond_ex & rd15;
      end
      S_EXECR, S_EXECI: begin
        srcb  = (state_q == S_EXECI) ?
                SRCB_IMM : SRCB_RD2;
        alu   = dp.alu;
        mov_o = dp.mov;
      end
      S_ALUWB: begin
        regw = cond_ex & ~dp.cmp;
        pcw  = cond_ex & ~dp.cmp & rd15;
      end
      S_BRANCH: begin
        srcb = SRCB_IMM;
        res  = RES_ALURES;
        pcw  = cond_ex;
      end
      default: ;
    endcase
  end

  // strobes are suppressed while reset is asserted
  assign bus.mem_req    = mreq & ~reset;
  assign bus.PCWrite    = pcw  & ~reset;
  assign bus.MemWrite   = memw & ~reset;
  assign bus.IRWrite    = irw  & ~reset;
  assign bus.RegWrite   = regw & ~reset;
  assign bus.AdrSrc     = adr;
  assign bus.ResultSrc  = res;
  assign bus.ALUSrcA    = srca;
  assign bus.ALUSrcB    = srcb;
  assign bus.ALUControl = ALUCTRL_W'(alu);
  assign bus.mov        = mov_o;
  assign bus.fault      = (state_q == S_FAULT) & ~reset;

  assign bus.ImmSrc = (op == OP_MEM) ? IMM_MEM :
                      (op == OP_BR)  ? IMM_BR  : IMM_DP;
  assign bus.RegSrc = {(op == OP_MEM) & ~l_bit,
                       (op == OP_BR)};

  generate
    if (TIMEOUT > 0) begin : g_tmo
      localparam int TW = $clog2(TIMEOUT + 1);
      logic [TW-1:0] tmo_q, tmo_d;

      assign timeout_hit =
        mem_wait & (tmo_q == TW'(TIMEOUT - 1));

      // wait counter restarts on ready or any state change
      always_comb begin
        tmo_d = tmo_q;
        if (bus.mem_ready || state_d != state_q)
          tmo_d = '0;
        else if (mem_wait)
          tmo_d = tmo_q + TW'(1);
      end

      // wait counter register
      always_ff @(posedge clk) begin
        if (reset) tmo_q <= '0;
        else       tmo_q <= tmo_d;
      end
    end else begin : g_no_tmo
      assign timeout_hit = 1'b0;
    end
  endgenerate

`ifdef ARM_PERF_EN
  logic [CNT_W-1:0] ret_q, ret_d;
  logic [CNT_W-1:0] stall_q, stall_d;

  // count completed instructions and memory wait cycles
  always_comb begin
    ret_d   = ret_q;
    stall_d = stall_q;
    if (state_d == S_FETCH && state_q != S_FETCH)
      ret_d = ret_q + CNT_W'(1);
    if (mem_wait)
      stall_d = stall_q + CNT_W'(1);
  end

  // performance counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      ret_q   <= '0;
      stall_q <= '0;
    end else begin
      ret_q   <= ret_d;
      stall_q <= stall_d;
    end
  end

  assign retired      = ret_q;
  assign stall_cycles = stall_q;
`else
  logic [CNT_W-1:0] unused_cnt_w;
  assign unused_cnt_w = '0;
`endif

endmodule
